// File: rtl/usb_pkg.sv
// usb_pkg
//   Shared definitions for the USB receive decoder: PID nibble values,
//   ERR_CODE reasons, CRC5/CRC16 polynomial/init/residual constants, the
//   decoder state enum and small PID helper functions.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TOKEN = 3'd1,
    ST_HS    = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    PK_TOKEN    = 3'd0,
    PK_HS       = 3'd1,
    PK_DATA     = 3'd2,
    PK_SPECIAL  = 3'd3,
    PK_RESERVED = 3'd4
  } pid_kind_e;

  // PID[3:0] values
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_SPLIT = 4'h8;
  localparam logic [3:0] PID_PRE   = 4'hC;

  // ERR_CODE reasons
  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_PID_CHECK = 3'd1;
  localparam logic [2:0] ERR_CRC5      = 3'd2;
  localparam logic [2:0] ERR_CRC16     = 3'd3;
  localparam logic [2:0] ERR_LENGTH    = 3'd4;
  localparam logic [2:0] ERR_OVERSIZE  = 3'd5;
  localparam logic [2:0] ERR_ABORT     = 3'd6;
  localparam logic [2:0] ERR_UNSUPP    = 3'd7;

  // CRCs: shift-left registers, data consumed LSB-first
  localparam int unsigned   CRC5_W         = 5;
  localparam logic [4:0]    CRC5_POLY      = 5'h05;
  localparam logic [4:0]    CRC5_INIT      = 5'h1F;
  localparam logic [4:0]    CRC5_RESIDUAL  = 5'h0C;
  localparam int unsigned   CRC16_W        = 16;
  localparam logic [15:0]   CRC16_POLY     = 16'h8005;
  localparam logic [15:0]   CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0]   CRC16_RESIDUAL = 16'h800D;

  // Upper nibble of a PID byte must be the complement of the lower one.
  function automatic logic pid_check_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  function automatic pid_kind_e pid_kind(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SETUP, PID_PING, PID_SOF:  return PK_TOKEN;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:          return PK_HS;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:     return PK_DATA;
      PID_SPLIT, PID_PRE:                             return PK_SPECIAL;
      default:                                        return PK_RESERVED;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_step.sv
// usb_crc_step
//   Combinational single-byte CRC update, bits consumed LSB-first into a
//   shift-left register (feedback = msb ^ data bit, XOR POLY when set).
//   Ports:
//     crc_in  [WIDTH-1:0]  current CRC register
//     data_in [7:0]        byte to fold in
//     crc_out [WIDTH-1:0]  CRC register after the byte
module usb_crc_step #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [WIDTH-1:0] crc_out
);

  logic [WIDTH-1:0] crc_v;
  logic             fb;

  always_comb begin
    crc_v = crc_in;
    fb    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      fb    = crc_v[WIDTH-1] ^ data_in[i];
      crc_v = {crc_v[WIDTH-2:0], 1'b0};
      if (fb) crc_v = crc_v ^ POLY;
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder
//   Packet-level receive decoder behind the ULPI link. Validates PID and
//   CRC, classifies token/SOF/handshake/data packets and forwards data
//   payload bytes with the trailing CRC16 stripped.
//   Ports:
//     CLK_60M, RST_USB                  clock, sync active-high reset
//     USB_DATA_OUT[7:0], *_STRB, *_END, *_FAIL   byte stream from ULPI
//     TOKEN_VALID/PID/ADDR/ENDP         decoded OUT/IN/SETUP/PING token
//     SOF_VALID/SOF_FRAME               decoded SOF
//     HS_VALID/HS_PID                   decoded handshake
//     DATA_START/PID/BYTE/STRB/END/OK   data packet stream
//     PKT_ERR/ERR_CODE                  rejection pulse and held reason
//     BUSY                              decoder not idle
//   All outputs are registered.
module usb_rx_decoder
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1024
) (
  input  logic        CLK_60M,
  input  logic        RST_USB,
  input  logic [7:0]  USB_DATA_OUT,
  input  logic        USB_DATA_OUT_STRB,
  input  logic        USB_DATA_OUT_END,
  input  logic        USB_DATA_OUT_FAIL,
  output logic        TOKEN_VALID,
  output logic [3:0]  TOKEN_PID,
  output logic [6:0]  TOKEN_ADDR,
  output logic [3:0]  TOKEN_ENDP,
  output logic        SOF_VALID,
  output logic [10:0] SOF_FRAME,
  output logic        HS_VALID,
  output logic [3:0]  HS_PID,
  output logic        DATA_START,
  output logic [3:0]  DATA_PID,
  output logic [7:0]  DATA_BYTE,
  output logic        DATA_STRB,
  output logic        DATA_END,
  output logic        DATA_OK,
  output logic        PKT_ERR,
  output logic [2:0]  ERR_CODE,
  output logic        BUSY
);

  localparam int unsigned CW      = $clog2(MAX_PAYLOAD + 3);
  // Count of bytes after the PID at which one more byte means oversize
  localparam logic [CW-1:0] OVF_CNT = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]      pid_q, pid_d;
  logic [4:0]      crc5_q, crc5_d, crc5_next;
  logic [15:0]     crc16_q, crc16_d, crc16_next;
  logic [7:0]      hold0_q, hold0_d;   // older held byte
  logic [7:0]      hold1_q, hold1_d;   // newest held byte

  logic            token_valid_q, token_valid_d;
  logic [3:0]      token_pid_q, token_pid_d;
  logic [6:0]      token_addr_q, token_addr_d;
  logic [3:0]      token_endp_q, token_endp_d;
  logic            sof_valid_q, sof_valid_d;
  logic [10:0]     sof_frame_q, sof_frame_d;
  logic            hs_valid_q, hs_valid_d;
  logic [3:0]      hs_pid_q, hs_pid_d;
  logic            data_start_q, data_start_d;
  logic [3:0]      data_pid_q, data_pid_d;
  logic [7:0]      data_byte_q, data_byte_d;
  logic            data_strb_q, data_strb_d;
  logic            data_end_q, data_end_d;
  logic            data_ok_q, data_ok_d;
  logic            pkt_err_q, pkt_err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;

  usb_crc_step #(.WIDTH(CRC5_W), .POLY(CRC5_POLY)) u_crc5 (
    .crc_in  (crc5_q),
    .data_in (USB_DATA_OUT),
    .crc_out (crc5_next)
  );

  usb_crc_step #(.WIDTH(CRC16_W), .POLY(CRC16_POLY)) u_crc16 (
    .crc_in  (crc16_q),
    .data_in (USB_DATA_OUT),
    .crc_out (crc16_next)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // The byte (if any) is applied first, producing the *_d values; END is
  // then judged on those post-byte values so STRB+END in one cycle works.
  // The PID is decoded in the IDLE cycle that receives it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pid_d         = pid_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    token_valid_d = 1'b0;
    token_pid_d   = token_pid_q;
    token_addr_d  = token_addr_q;
    token_endp_d  = token_endp_q;
    sof_valid_d   = 1'b0;
    sof_frame_d   = sof_frame_q;
    hs_valid_d    = 1'b0;
    hs_pid_d      = hs_pid_q;
    data_start_d  = 1'b0;
    data_pid_d    = data_pid_q;
    data_byte_d   = data_byte_q;
    data_strb_d   = 1'b0;
    data_end_d    = 1'b0;
    data_ok_d     = 1'b0;
    pkt_err_d     = 1'b0;
    err_code_d    = err_code_q;

    if (USB_DATA_OUT_FAIL && (state_q != ST_IDLE)) begin
      pkt_err_d  = 1'b1;
      err_code_d = ERR_ABORT;
      if (state_q == ST_DATA) data_end_d = 1'b1;
      state_d    = ST_IDLE;
    end else begin
      if (USB_DATA_OUT_STRB) begin
        case (state_q)
          ST_IDLE: begin
            pid_d   = USB_DATA_OUT[3:0];
            cnt_d   = '0;
            crc5_d  = CRC5_INIT;
            crc16_d = CRC16_INIT;
            if (!pid_check_ok(USB_DATA_OUT)) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_PID_CHECK;
              state_d    = ST_DRAIN;
            end else begin
              case (pid_kind(USB_DATA_OUT[3:0]))
                PK_TOKEN: state_d = ST_TOKEN;
                PK_HS:    state_d = ST_HS;
                PK_DATA: begin
                  data_start_d = 1'b1;
                  data_pid_d   = USB_DATA_OUT[3:0];
                  state_d      = ST_DATA;
                end
                default: begin
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_UNSUPP;
                  state_d    = ST_DRAIN;
                end
              endcase
            end
          end
          ST_TOKEN: begin
            crc5_d  = crc5_next;
            hold0_d = hold1_q;
            hold1_d = USB_DATA_OUT;
            cnt_d   = cnt_inc;
          end
          ST_HS: begin
            cnt_d = cnt_inc;
          end
          ST_DATA: begin
            if (cnt_q >= OVF_CNT) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_OVERSIZE;
              data_end_d = 1'b1;
              state_d    = ST_DRAIN;
            end else begin
              // Once two bytes are held, the oldest is known to be payload
              if (cnt_q >= CNT_TWO) begin
                data_byte_d = hold0_q;
                data_strb_d = 1'b1;
              end
              crc16_d = crc16_next;
              hold0_d = hold1_q;
              hold1_d = USB_DATA_OUT;
              cnt_d   = cnt_inc;
            end
          end
          default: ;
        endcase
      end

      if (USB_DATA_OUT_END) begin
        case (state_d)
          ST_TOKEN: begin
            if (cnt_d != CNT_TWO) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_LENGTH;
            end else if (crc5_d != CRC5_RESIDUAL) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_CRC5;
            end else if (pid_d == PID_SOF) begin
              sof_valid_d = 1'b1;
              sof_frame_d = {hold1_d[2:0], hold0_d};
            end else begin
              token_valid_d = 1'b1;
              token_pid_d   = pid_d;
              token_addr_d  = hold0_d[6:0];
              token_endp_d  = {hold1_d[2:0], hold0_d[7]};
            end
          end
          ST_HS: begin
            if (cnt_d != '0) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_LENGTH;
            end else begin
              hs_valid_d = 1'b1;
              hs_pid_d   = pid_d;
            end
          end
          ST_DATA: begin
            data_end_d = 1'b1;
            if (cnt_d < CNT_TWO) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_LENGTH;
            end else if (crc16_d != CRC16_RESIDUAL) begin
              pkt_err_d  = 1'b1;
              err_code_d = ERR_CRC16;
            end else begin
              data_ok_d = 1'b1;
            end
          end
          default: ;
        endcase
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pid_q         <= '0;
      crc5_q        <= '0;
      crc16_q       <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
      token_valid_q <= 1'b0;
      token_pid_q   <= '0;
      token_addr_q  <= '0;
      token_endp_q  <= '0;
      sof_valid_q   <= 1'b0;
      sof_frame_q   <= '0;
      hs_valid_q    <= 1'b0;
      hs_pid_q      <= '0;
      data_start_q  <= 1'b0;
      data_pid_q    <= '0;
      data_byte_q   <= '0;
      data_strb_q   <= 1'b0;
      data_end_q    <= 1'b0;
      data_ok_q     <= 1'b0;
      pkt_err_q     <= 1'b0;
      err_code_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pid_q         <= pid_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      token_valid_q <= token_valid_d;
      token_pid_q   <= token_pid_d;
      token_addr_q  <= token_addr_d;
      token_endp_q  <= token_endp_d;
      sof_valid_q   <= sof_valid_d;
      sof_frame_q   <= sof_frame_d;
      hs_valid_q    <= hs_valid_d;
      hs_pid_q      <= hs_pid_d;
      data_start_q  <= data_start_d;
      data_pid_q    <= data_pid_d;
      data_byte_q   <= data_byte_d;
      data_strb_q   <= data_strb_d;
      data_end_q    <= data_end_d;
      data_ok_q     <= data_ok_d;
      pkt_err_q     <= pkt_err_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign TOKEN_VALID = token_valid_q;
  assign TOKEN_PID   = token_pid_q;
  assign TOKEN_ADDR  = token_addr_q;
  assign TOKEN_ENDP  = token_endp_q;
  assign SOF_VALID   = sof_valid_q;
  assign SOF_FRAME   = sof_frame_q;
  assign HS_VALID    = hs_valid_q;
  assign HS_PID      = hs_pid_q;
  assign DATA_START  = data_start_q;
  assign DATA_PID    = data_pid_q;
  assign DATA_BYTE   = data_byte_q;
  assign DATA_STRB   = data_strb_q;
  assign DATA_END    = data_end_q;
  assign DATA_OK     = data_ok_q;
  assign PKT_ERR     = pkt_err_q;
  assign ERR_CODE    = err_code_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder
//   Directed bench for usb_rx_decoder (MAX_PAYLOAD overridden to 8 so the
//   8-byte setup payload sits exactly on the size limit).
module tb_usb_rx_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        strb, pend, pfail;

  logic        TOKEN_VALID, SOF_VALID, HS_VALID, DATA_START, DATA_STRB;
  logic        DATA_END, DATA_OK, PKT_ERR, BUSY;
  logic [3:0]  TOKEN_PID, TOKEN_ENDP, HS_PID, DATA_PID;
  logic [6:0]  TOKEN_ADDR;
  logic [10:0] SOF_FRAME;
  logic [7:0]  DATA_BYTE;
  logic [2:0]  ERR_CODE;

  int n_assert = 0;
  int n_fail   = 0;

  int          dend_cnt = 0;
  int          err_cnt  = 0;
  int          tok_cnt  = 0;
  logic [7:0]  rx_bytes[$];

  logic [7:0]  pkt [10];

  always #5 clk = ~clk;

  usb_rx_decoder #(.MAX_PAYLOAD(8)) dut (
    .CLK_60M           (clk),
    .RST_USB           (rst),
    .USB_DATA_OUT      (din),
    .USB_DATA_OUT_STRB (strb),
    .USB_DATA_OUT_END  (pend),
    .USB_DATA_OUT_FAIL (pfail),
    .TOKEN_VALID       (TOKEN_VALID),
    .TOKEN_PID         (TOKEN_PID),
    .TOKEN_ADDR        (TOKEN_ADDR),
    .TOKEN_ENDP        (TOKEN_ENDP),
    .SOF_VALID         (SOF_VALID),
    .SOF_FRAME         (SOF_FRAME),
    .HS_VALID          (HS_VALID),
    .HS_PID            (HS_PID),
    .DATA_START        (DATA_START),
    .DATA_PID          (DATA_PID),
    .DATA_BYTE         (DATA_BYTE),
    .DATA_STRB         (DATA_STRB),
    .DATA_END          (DATA_END),
    .DATA_OK           (DATA_OK),
    .PKT_ERR           (PKT_ERR),
    .ERR_CODE          (ERR_CODE),
    .BUSY              (BUSY)
  );

  // Pulse/byte recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (DATA_STRB)   rx_bytes.push_back(DATA_BYTE);
    if (DATA_END)    dend_cnt++;
    if (PKT_ERR)     err_cnt++;
    if (TOKEN_VALID) tok_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of link stimulus; on return the registered outputs reflect it
  task automatic put(input logic s, input logic [7:0] d, input logic e, input logic f);
    strb  = s;
    din   = d;
    pend  = e;
    pfail = f;
    @(negedge clk);
    #1;
    strb  = 1'b0;
    pend  = 1'b0;
    pfail = 1'b0;
  endtask

  // Payload + CRC of the setup data packet, last byte substitutable
  task automatic send_data(input logic [7:0] last);
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 9) ? last : pkt[i];
      put(1'b1, b, 1'b0, 1'b0);
      if (i >= 2) begin
        check("data_strb_on", {31'd0, DATA_STRB}, 32'd1);
        check("data_byte", {24'd0, DATA_BYTE}, {24'd0, pkt[i-2]});
      end else begin
        check("data_strb_early", {31'd0, DATA_STRB}, 32'd0);
      end
    end
  endtask

  initial begin
    int base_bytes, base_dend, base_err, base_tok;
    pkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    rst = 1'b1; din = '0; strb = 1'b0; pend = 1'b0; pfail = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_flags", {23'd0, TOKEN_VALID, SOF_VALID, HS_VALID, DATA_START, DATA_STRB,
                        DATA_END, DATA_OK, PKT_ERR, BUSY}, 32'd0);
    check("rst_token", {17'd0, TOKEN_PID, TOKEN_ADDR, TOKEN_ENDP}, 32'd0);
    check("rst_fields", {SOF_FRAME, HS_PID, DATA_PID, DATA_BYTE, ERR_CODE}, 32'd0);
    rst = 1'b0;

    // Token SETUP addr 0 endp 0
    put(1'b1, 8'h2D, 1'b0, 1'b0);
    check("token_busy", {31'd0, BUSY}, 32'd1);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b1, 8'h10, 1'b0, 1'b0);
    check("token_no_early", {31'd0, TOKEN_VALID}, 32'd0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("token_valid", {31'd0, TOKEN_VALID}, 32'd1);
    check("token_fields", {17'd0, TOKEN_PID, TOKEN_ADDR, TOKEN_ENDP}, {17'd0, 4'hD, 7'd0, 4'd0});
    check("token_no_err", {31'd0, PKT_ERR}, 32'd0);
    check("token_idle", {31'd0, BUSY}, 32'd0);

    // Back-to-back token, last byte and END in the same cycle
    put(1'b1, 8'h2D, 1'b0, 1'b0);
    check("token_pulse_clear", {31'd0, TOKEN_VALID}, 32'd0);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b1, 8'h10, 1'b1, 1'b0);
    check("token_strb_end", {31'd0, TOKEN_VALID}, 32'd1);

    // Good DATA0 packet
    base_bytes = rx_bytes.size();
    put(1'b1, 8'hC3, 1'b0, 1'b0);
    check("data_start", {31'd0, DATA_START}, 32'd1);
    check("data_pid", {28'd0, DATA_PID}, 32'h3);
    send_data(8'h94);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("data_end", {30'd0, DATA_END, DATA_OK}, 32'b11);
    check("data_ok_no_err", {31'd0, PKT_ERR}, 32'd0);
    check("data_count", rx_bytes.size() - base_bytes, 32'd8);

    // Same packet with corrupted CRC
    base_bytes = rx_bytes.size();
    put(1'b1, 8'hC3, 1'b0, 1'b0);
    send_data(8'h95);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("crc_end", {30'd0, DATA_END, DATA_OK}, 32'b10);
    check("crc_err", {28'd0, PKT_ERR, ERR_CODE}, {28'd0, 1'b1, 3'd3});
    check("crc_count", rx_bytes.size() - base_bytes, 32'd8);

    // Handshakes; ERR_CODE keeps the earlier reason
    put(1'b1, 8'hD2, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("hs_valid", {27'd0, HS_VALID, HS_PID}, {27'd0, 1'b1, 4'h2});
    check("hs_err_held", {28'd0, PKT_ERR, ERR_CODE}, {28'd0, 1'b0, 3'd3});
    put(1'b1, 8'h1E, 1'b1, 1'b0);
    check("hs_strb_end", {27'd0, HS_VALID, HS_PID}, {27'd0, 1'b1, 4'hE});
    put(1'b1, 8'hD3, 1'b0, 1'b0);
    check("pid_bad", {28'd0, PKT_ERR, ERR_CODE}, {28'd0, 1'b1, 3'd1});
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("pid_bad_end", {29'd0, HS_VALID, PKT_ERR, BUSY}, 32'd0);
    put(1'b1, 8'h5A, 1'b0, 1'b0);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("hs_extra", {27'd0, HS_VALID, PKT_ERR, ERR_CODE}, {27'd0, 1'b0, 1'b1, 3'd4});

    // Token CRC5 error and short token
    put(1'b1, 8'h2D, 1'b0, 1'b0);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b1, 8'h11, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("token_crc5", {27'd0, TOKEN_VALID, PKT_ERR, ERR_CODE}, {27'd0, 1'b0, 1'b1, 3'd2});
    put(1'b1, 8'h2D, 1'b0, 1'b0);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("token_short", {27'd0, TOKEN_VALID, PKT_ERR, ERR_CODE}, {27'd0, 1'b0, 1'b1, 3'd4});

    // SPLIT is rejected at the PID and drained
    put(1'b1, 8'h78, 1'b0, 1'b0);
    check("split", {27'd0, BUSY, PKT_ERR, ERR_CODE}, {27'd0, 1'b1, 1'b1, 3'd7});
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("split_drained", {30'd0, BUSY, PKT_ERR}, 32'd0);

    // Abort with FAIL and END together, then SOF frame 0x401
    base_bytes = rx_bytes.size();
    put(1'b1, 8'hC3, 1'b0, 1'b0);
    put(1'b1, 8'h01, 1'b0, 1'b0);
    put(1'b1, 8'h02, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b1);
    check("abort_end", {30'd0, DATA_END, DATA_OK}, 32'b10);
    check("abort_err", {28'd0, PKT_ERR, ERR_CODE}, {28'd0, 1'b1, 3'd6});
    check("abort_no_bytes", rx_bytes.size() - base_bytes, 32'd0);
    put(1'b1, 8'hA5, 1'b0, 1'b0);
    put(1'b1, 8'h01, 1'b0, 1'b0);
    put(1'b1, 8'h4C, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("sof", {20'd0, SOF_VALID, SOF_FRAME}, {20'd0, 1'b1, 11'h401});
    check("sof_not_token", {30'd0, TOKEN_VALID, PKT_ERR}, 32'd0);

    // FAIL and END while idle are ignored
    put(1'b0, 8'h00, 1'b1, 1'b1);
    check("idle_fail", {29'd0, PKT_ERR, DATA_END, BUSY}, 32'd0);

    // Oversize: 9 payload bytes + 2 more exceeds MAX_PAYLOAD=8
    base_bytes = rx_bytes.size();
    base_dend  = dend_cnt;
    put(1'b1, 8'h4B, 1'b0, 1'b0);
    check("ovf_start", {27'd0, DATA_START, DATA_PID}, {27'd0, 1'b1, 4'hB});
    for (int i = 0; i < 10; i++) put(1'b1, 8'(i + 1), 1'b0, 1'b0);
    check("ovf_not_yet", {30'd0, DATA_END, PKT_ERR}, 32'd0);
    put(1'b1, 8'h0B, 1'b0, 1'b0);
    check("ovf_end", {28'd0, DATA_END, DATA_OK, DATA_STRB, PKT_ERR}, 32'b1001);
    check("ovf_code", {28'd0, BUSY, ERR_CODE}, {28'd0, 1'b1, 3'd5});
    put(1'b1, 8'h0C, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("ovf_drained", {29'd0, DATA_END, PKT_ERR, BUSY}, 32'd0);
    check("ovf_bytes", rx_bytes.size() - base_bytes, 32'd8);
    check("ovf_single_end", dend_cnt - base_dend, 32'd1);

    // Reset mid-DATA, then a clean token
    base_dend = dend_cnt;
    base_err  = err_cnt;
    base_tok  = tok_cnt;
    put(1'b1, 8'hC3, 1'b0, 1'b0);
    put(1'b1, 8'h80, 1'b0, 1'b0);
    put(1'b1, 8'h06, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
    put(1'b1, 8'h2D, 1'b0, 1'b0);
    put(1'b1, 8'h00, 1'b0, 1'b0);
    put(1'b1, 8'h10, 1'b0, 1'b0);
    put(1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_token", {20'd0, TOKEN_VALID, TOKEN_PID, TOKEN_ADDR}, {20'd0, 1'b1, 4'hD, 7'd0});
    put(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_no_stale_end", dend_cnt - base_dend, 32'd0);
    check("rst_no_err", err_cnt - base_err, 32'd0);
    check("rst_one_token", tok_cnt - base_tok, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
